nano_io_device: RTL

Peripheral responder for the nano CPU's device-select I/O bus. It decodes four consecutive device numbers and serves CPU reads (INA) and writes (OTA/OTR) to a 4-entry receive FIFO, a transmit holding register, an 8-bit prescaled down-timer and a control register. It raises the CPU interrupt request and drives the interrupt vector onto the data bus during the CPU's acknowledge cycle.

---
 rtl/nano_io_device_if.sv | 29 ++
 rtl/nano_io_device.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nano_io_device_if.sv
// Device-select I/O bus, interrupt and rx/tx byte-stream signals of nano_io_device.
// Latency: none, wires only.
// Backpressure: rx_valid/rx_ready and tx_valid/tx_ready, transfer on valid & ready at posedge.
// master = CPU + stream environment, slave = the device.
interface nano_io_device_if;
    logic [3:0] ds;         // device select, F = idle
    logic       rw;         // 1 = write (OTA/OTR), 0 = read (INA)
    logic [7:0] bus_d_in;   // write data from CPU
    logic [7:0] bus_d_out;  // read data / interrupt vector
    logic       bus_d_oe;   // drive enable for bus_d_out
    logic       int_req;    // level interrupt request
    logic       int_ack;    // one-cycle acknowledge
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output ds, rw, bus_d_in, int_ack, rx_data, rx_valid, tx_ready,
        input  bus_d_out, bus_d_oe, int_req, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  ds, rw, bus_d_in, int_ack, rx_data, rx_valid, tx_ready,
        output bus_d_out, bus_d_oe, int_req, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/nano_io_device.sv
// nano CPU I/O responder: 4-deep rx FIFO, tx holding register, prescaled down-timer, ctrl, irq.
// Latency: read data combinational in the access cycle; side effects commit at the closing edge.
// Backpressure: rx_ready drops when the FIFO is full; tx writes are dropped while tx_valid is high.
// Ports: clk, rst (sync, active-high), bus (nano_io_device_if.slave).
// Registers (offset from BASE): 0 DATA, 1 STATUS, 2 TIMER, 3 CTRL.
module nano_io_device #(
    parameter logic [3:0] BASE    = 4'h0,
    parameter logic [7:0] VEC_RX  = 8'h10,
    parameter logic [7:0] VEC_TMR = 8'h20
) (
    input logic             clk,
    input logic             rst,
    nano_io_device_if.slave bus
);

    // rx FIFO
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;

    // tx holding register
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;

    // control and timer
    logic [4:0] ctrl_q, ctrl_d;         // [0] rx_ie [1] tmr_ie [2] tmr_run [4:3] prescale
    logic [7:0] tmr_cnt_q, tmr_cnt_d;
    logic [7:0] reload_q, reload_d;
    logic [5:0] presc_q, presc_d;
    logic       tmr_pend_q, tmr_pend_d;
    logic       int_req_q, int_req_d;

    logic       sel, rd_en, wr_en, vec_en;
    logic [1:0] off;
    logic       rx_ne, rx_full, rx_rdy;
    logic       rx_src, tmr_src;
    logic       push, pop, tick;
    logic [5:0] presc_last;
    logic [7:0] rd_data;

    assign sel     = (bus.ds[3:2] == BASE[3:2]) && (bus.ds != 4'hF);
    assign off     = bus.ds[1:0];
    assign rx_ne   = (cnt_q != 3'd0);
    assign rx_full = (cnt_q == 3'd4);
    assign rx_rdy  = !rx_full && !rst;
    assign rx_src  = rx_ne && ctrl_q[0];
    assign tmr_src = tmr_pend_q && ctrl_q[1];

    // The acknowledge vector wins the bus over a coinciding read; that read
    // then has no side effects so a FIFO byte is never lost unseen.
    assign vec_en = bus.int_ack && (rx_src || tmr_src);
    assign rd_en  = sel && !bus.rw && !vec_en;
    assign wr_en  = sel && bus.rw;

    assign pop  = rd_en && (off == 2'd0) && rx_ne;
    assign push = bus.rx_valid && rx_rdy;

    // Prescaler counts 0..N-1; '>=' keeps it ticking if the ratio is
    // lowered while the counter is above the new terminal value.
    always_comb begin
        case (ctrl_q[4:3])
            2'd0:    presc_last = 6'd0;
            2'd1:    presc_last = 6'd3;
            2'd2:    presc_last = 6'd15;
            default: presc_last = 6'd63;
        endcase
    end
    assign tick = ctrl_q[2] && (presc_q >= presc_last);

    always_comb begin
        rd_data = 8'h00;
        case (off)
            2'd0:    rd_data = rx_ne ? fifo_q[rd_ptr_q] : 8'h00;
            2'd1:    rd_data = {tmr_pend_q, rx_ne, tx_valid_q, rx_full, int_req_q, cnt_q};
            2'd2:    rd_data = tmr_cnt_q;
            default: rd_data = {3'b000, ctrl_q};
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 3'd1;
        end

        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (wr_en && (off == 2'd0) && !tx_valid_q) begin
            tx_data_d  = bus.bus_d_in;
            tx_valid_d = 1'b1;
        end

        ctrl_d = (wr_en && (off == 2'd3)) ? bus.bus_d_in[4:0] : ctrl_q;

        // Clears first, so an underflow in the same cycle overrides them.
        tmr_pend_d = tmr_pend_q;
        if (vec_en && !rx_src) begin
            tmr_pend_d = 1'b0;
        end
        if (wr_en && (off == 2'd1) && bus.bus_d_in[7]) begin
            tmr_pend_d = 1'b0;
        end

        tmr_cnt_d = tmr_cnt_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        if (wr_en && (off == 2'd2)) begin
            reload_d  = bus.bus_d_in;
            tmr_cnt_d = bus.bus_d_in;
            presc_d   = 6'd0;
        end else if (ctrl_q[2]) begin
            if (tick) begin
                presc_d = 6'd0;
                if (tmr_cnt_q == 8'd0) begin
                    tmr_cnt_d  = reload_q;
                    tmr_pend_d = 1'b1;
                end else begin
                    tmr_cnt_d = tmr_cnt_q - 8'd1;
                end
            end else begin
                presc_d = presc_q + 6'd1;
            end
        end

        int_req_d = rx_src || tmr_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h00;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            cnt_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ctrl_q     <= 5'd0;
            tmr_cnt_q  <= 8'h00;
            reload_q   <= 8'h00;
            presc_q    <= 6'd0;
            tmr_pend_q <= 1'b0;
            int_req_q  <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.rx_data;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ctrl_q     <= ctrl_d;
            tmr_cnt_q  <= tmr_cnt_d;
            reload_q   <= reload_d;
            presc_q    <= presc_d;
            tmr_pend_q <= tmr_pend_d;
            int_req_q  <= int_req_d;
        end
    end

    assign bus.bus_d_oe  = !rst && (vec_en || (sel && !bus.rw));
    assign bus.bus_d_out = rst    ? 8'h00 :
                           vec_en ? (rx_src ? VEC_RX : VEC_TMR) :
                           rd_en  ? rd_data : 8'h00;
    assign bus.int_req   = int_req_q;
    assign bus.rx_ready  = rx_rdy;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;

endmodule
